rx_link_controller: RTL and testbench
=====================================

# rx_link_controller

Receive-side link controller that sits between the serial-to-parallel converter and the four byte lanes. Monitors the recovered byte stream for the 0xBC comma, commands bit-slip until byte alignment is found, and declares the link active after a run of consecutive commas. While active, it strips commas and distributes data bytes round-robin to lanes 0-3 with a per-byte valid, and drops back to search if commas stop arriving.

## Interface
Parameters:
- COMMA, 8'hBC, alignment/idle symbol
- BC_LOCK, 4, consecutive commas required to go active (2..15)
- SLIP_AFTER, 8, consecutive non-comma bytes in SEARCH before a bit-slip request (2..255)
- MAX_GAP, 16, maximum data bytes between commas in ACTIVE (1..255)

Ports:
- clk_4f  in  1  sole clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- in_byte  in  8  parallel byte from serial-to-parallel converter
- in_byte_valid  in  1  one-cycle strobe, in_byte is valid this cycle
- bit_slip  out  1  one-cycle pulse, converter shifts its byte boundary one bit
- active  out  1  link aligned and forwarding data
- lane_data  out  8  forwarded data byte
- lane_sel  out  2  destination lane of lane_data
- lane_valid  out  1  lane_data/lane_sel valid this cycle
- slip_count  out  4  saturating count of bit_slip pulses since last reset

## Operation
- States: SEARCH, ALIGN, ACTIVE. Reset state SEARCH.
- All state changes and counter updates happen only on cycles with in_byte_valid=1. With in_byte_valid=0 every counter, the pointer and the state hold; lane_valid and bit_slip are 0.
- SEARCH: byte==COMMA -> ALIGN, bc_cnt=1, miss_cnt=0. Otherwise miss_cnt++; when miss_cnt reaches SLIP_AFTER, pulse bit_slip, miss_cnt=0, slip_count++ (saturates at 15).
- ALIGN: byte==COMMA -> bc_cnt++; reaching BC_LOCK -> ACTIVE, gap_cnt=0, lane_ptr=0. Non-comma -> SEARCH, bc_cnt=0, miss_cnt=1.
- ACTIVE: byte==COMMA -> not forwarded; gap_cnt=0; lane_ptr=0 (lane 0 always first after an idle). Non-comma -> forwarded with lane_sel=lane_ptr; lane_ptr increments mod 4 (3 wraps to 0); gap_cnt++. If gap_cnt reaches MAX_GAP with this non-comma byte, the byte is still forwarded and the state goes to SEARCH next cycle, with counters cleared.
- active=1 exactly while the state is ACTIVE.
- No bit_slip is issued outside SEARCH.

## Timing
- All outputs registered. Reset values: bit_slip=0, active=0, lane_data=8'h00, lane_sel=0, lane_valid=0, slip_count=0. Internal counters, lane_ptr and state are also reset.
- Forwarding latency: in_byte accepted at edge N appears on lane_data with lane_valid=1 during the cycle after edge N (1 cycle).
- active rises in the cycle after the edge that samples the BC_LOCK-th comma. It falls in the cycle after the MAX_GAP-th gap byte.
- bit_slip is high for exactly one clk_4f cycle, in the cycle after the SLIP_AFTER-th miss.
- reset asserted mid-operation overrides in_byte_valid in the same edge. All outputs take their reset values next cycle. A partially collected comma run is discarded.

## Structure
- Package rx_link_pkg: state enum (SEARCH, ALIGN, ACTIVE), default COMMA constant, counter widths.
- Sub-module rx_sat_counter: clear/increment/saturate counter with terminal-count flag, instantiated for miss_cnt, bc_cnt and gap_cnt.
- Top block holds the FSM, lane_ptr and output registers.

## Test plan
- Reset, then 4× 0xBC with valid every 4th cycle -> active=1 one cycle after the 4th comma; bit_slip never asserted; slip_count=0.
- Reset, then 8× 0x5E -> one bit_slip pulse after the 8th byte, slip_count=1. Next 4× 0xBC -> active=1.
- Active link, then bytes 0x11,0x22,0x33,0x44,0x55 -> lane_sel 0,1,2,3,0 with matching lane_data and lane_valid=1, each 1 cycle after acceptance. Then 0xBC, 0x66 -> no output for the comma; 0x66 on lane 0.
- Active link, then 16 consecutive non-comma bytes -> all 16 forwarded; active=0 the cycle after the 16th. 0xBC,0xBC,0xBC,0x01 -> back to SEARCH with active=0, no forwarding.
- Three commas then reset=1 for one cycle, then one comma -> active stays 0. Four more commas are needed to reach active=1.
- in_byte_valid held low 20 cycles while ACTIVE -> active stays 1, no lane_valid, lane_ptr unchanged on resume.

Source files
------------

// File: rtl/rx_link_pkg.sv
// Shared types and widths for the receive-side link controller.
package rx_link_pkg;

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_ALIGN  = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   localparam logic [7:0]  DEFAULT_COMMA = 8'hBC;

   localparam int unsigned MISS_W     = 8;
   localparam int unsigned BC_W       = 4;
   localparam int unsigned GAP_W      = 8;
   localparam int unsigned LANE_W     = 2;
   localparam int unsigned SLIP_CNT_W = 4;

endpackage

// File: rtl/rx_sat_counter.sv
// Clear/increment counter that holds at its terminal count; clear+inc loads one.
module rx_sat_counter #(
   parameter int unsigned  W  = 8,
   parameter logic [W-1:0] TC = '1
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clr,
   input  logic i_inc,
   output logic o_tc_c
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= i_inc ? W'(1) : '0;
      end else if (i_inc && (r_count != TC)) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_tc_c = (r_count == TC);

endmodule

// File: rtl/rx_link_controller.sv
// Comma-based byte alignment, link activation and round-robin lane distribution.
module rx_link_controller
   import rx_link_pkg::*;
#(
   parameter logic [7:0]  COMMA      = DEFAULT_COMMA,
   parameter int unsigned BC_LOCK    = 4,
   parameter int unsigned SLIP_AFTER = 8,
   parameter int unsigned MAX_GAP    = 16
) (
   input  logic                  clk_4f,
   input  logic                  reset,
   input  logic [7:0]            in_byte,
   input  logic                  in_byte_valid,
   output logic                  bit_slip,
   output logic                  active,
   output logic [7:0]            lane_data,
   output logic [LANE_W-1:0]     lane_sel,
   output logic                  lane_valid,
   output logic [SLIP_CNT_W-1:0] slip_count
);

   state_t              r_state;
   logic [LANE_W-1:0]   r_lane_ptr;

   logic w_is_comma;
   logic w_miss_clr, w_miss_inc, w_miss_tc;
   logic w_bc_clr,   w_bc_inc,   w_bc_tc;
   logic w_gap_clr,  w_gap_inc,  w_gap_tc;

   assign w_is_comma = (in_byte == COMMA);

   // Terminal flags fire one short of the limit, so the limiting byte itself triggers the action.
   rx_sat_counter #(.W(MISS_W), .TC(MISS_W'(SLIP_AFTER - 1))) u_miss_cnt (
      .i_clk(clk_4f), .i_reset(reset), .i_clr(w_miss_clr), .i_inc(w_miss_inc), .o_tc_c(w_miss_tc)
   );

   rx_sat_counter #(.W(BC_W), .TC(BC_W'(BC_LOCK - 1))) u_bc_cnt (
      .i_clk(clk_4f), .i_reset(reset), .i_clr(w_bc_clr), .i_inc(w_bc_inc), .o_tc_c(w_bc_tc)
   );

   rx_sat_counter #(.W(GAP_W), .TC(GAP_W'(MAX_GAP - 1))) u_gap_cnt (
      .i_clk(clk_4f), .i_reset(reset), .i_clr(w_gap_clr), .i_inc(w_gap_inc), .o_tc_c(w_gap_tc)
   );

   // Counter controls; nothing moves on cycles without a valid byte.
   always_comb begin
      w_miss_clr = 1'b0;
      w_miss_inc = 1'b0;
      w_bc_clr   = 1'b0;
      w_bc_inc   = 1'b0;
      w_gap_clr  = 1'b0;
      w_gap_inc  = 1'b0;
      if (in_byte_valid) begin
         unique case (r_state)
            ST_SEARCH: begin
               if (w_is_comma) begin
                  w_miss_clr = 1'b1;
                  w_bc_clr   = 1'b1;
                  w_bc_inc   = 1'b1;
               end else if (w_miss_tc) begin
                  w_miss_clr = 1'b1;
               end else begin
                  w_miss_inc = 1'b1;
               end
            end
            ST_ALIGN: begin
               if (w_is_comma) begin
                  if (w_bc_tc) begin
                     w_bc_clr  = 1'b1;
                     w_gap_clr = 1'b1;
                  end else begin
                     w_bc_inc  = 1'b1;
                  end
               end else begin
                  w_bc_clr   = 1'b1;
                  w_miss_clr = 1'b1;
                  w_miss_inc = 1'b1;
               end
            end
            ST_ACTIVE: begin
               if (w_is_comma) begin
                  w_gap_clr = 1'b1;
               end else if (w_gap_tc) begin
                  w_gap_clr  = 1'b1;
                  w_miss_clr = 1'b1;
                  w_bc_clr   = 1'b1;
               end else begin
                  w_gap_inc  = 1'b1;
               end
            end
            default: begin
               w_miss_clr = 1'b1;
               w_bc_clr   = 1'b1;
               w_gap_clr  = 1'b1;
            end
         endcase
      end
   end

   // State, lane pointer and registered outputs.
   always_ff @(posedge clk_4f) begin
      if (reset) begin
         r_state    <= ST_SEARCH;
         r_lane_ptr <= '0;
         bit_slip   <= 1'b0;
         active     <= 1'b0;
         lane_data  <= 8'h00;
         lane_sel   <= '0;
         lane_valid <= 1'b0;
         slip_count <= '0;
      end else begin
         bit_slip   <= 1'b0;
         lane_valid <= 1'b0;
         if (in_byte_valid) begin
            unique case (r_state)
               ST_SEARCH: begin
                  if (w_is_comma) begin
                     r_state <= ST_ALIGN;
                  end else if (w_miss_tc) begin
                     bit_slip <= 1'b1;
                     if (slip_count != '1) begin
                        slip_count <= slip_count + SLIP_CNT_W'(1);
                     end
                  end
               end
               ST_ALIGN: begin
                  if (!w_is_comma) begin
                     r_state <= ST_SEARCH;
                  end else if (w_bc_tc) begin
                     r_state    <= ST_ACTIVE;
                     active     <= 1'b1;
                     r_lane_ptr <= '0;
                  end
               end
               ST_ACTIVE: begin
                  if (w_is_comma) begin
                     r_lane_ptr <= '0;
                  end else begin
                     lane_data  <= in_byte;
                     lane_sel   <= r_lane_ptr;
                     lane_valid <= 1'b1;
                     r_lane_ptr <= r_lane_ptr + LANE_W'(1);
                     if (w_gap_tc) begin
                        r_state    <= ST_SEARCH;
                        active     <= 1'b0;
                        r_lane_ptr <= '0;
                     end
                  end
               end
               default: begin
                  r_state    <= ST_SEARCH;
                  active     <= 1'b0;
                  r_lane_ptr <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_rx_link_controller.sv
// Directed, table-driven bench for rx_link_controller with default parameters.
module tb_rx_link_controller;

   localparam logic [7:0] BC = 8'hBC;

   logic       clk_4f = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] in_byte = 8'h00;
   logic       in_byte_valid = 1'b0;
   logic       bit_slip, active, lane_valid;
   logic [7:0] lane_data;
   logic [1:0] lane_sel;
   logic [3:0] slip_count;

   rx_link_controller dut (
      .clk_4f(clk_4f), .reset(reset), .in_byte(in_byte), .in_byte_valid(in_byte_valid),
      .bit_slip(bit_slip), .active(active), .lane_data(lane_data), .lane_sel(lane_sel),
      .lane_valid(lane_valid), .slip_count(slip_count)
   );

   always #5 clk_4f = ~clk_4f;

   typedef struct packed {
      logic       bs;
      logic       act;
      logic       lv;
      logic [7:0] data;
      logic [1:0] sel;
      logic [3:0] sc;
   } obs_t;

   typedef struct {
      logic       rst;
      logic       vld;
      logic [7:0] b;
      obs_t       exp;
   } vec_t;

   vec_t vecs[$];
   int   n_cmp  = 0;
   int   n_fail = 0;

   // Sticky expected values, updated by hand as the scenario is written.
   logic       e_act = 1'b0;
   logic [7:0] e_data = 8'h00;
   logic [1:0] e_sel = 2'd0;
   logic [3:0] e_sc = 4'd0;

   function automatic obs_t mk(input logic bs, input logic lv);
      obs_t o;
      o.bs = bs; o.act = e_act; o.lv = lv; o.data = e_data; o.sel = e_sel; o.sc = e_sc;
      return o;
   endfunction

   task automatic add(input logic rst, input logic vld, input logic [7:0] b,
                      input logic bs, input logic lv);
      vec_t t;
      t.rst = rst; t.vld = vld; t.b = b; t.exp = mk(bs, lv);
      vecs.push_back(t);
   endtask

   task automatic drive(input logic rst, input logic vld, input logic [7:0] b);
      @(negedge clk_4f);
      reset = rst; in_byte_valid = vld; in_byte = b;
      @(posedge clk_4f);
      #1;
   endtask

   task automatic check(input string nm, input obs_t exp);
      obs_t got;
      got = {bit_slip, active, lane_valid, lane_data, lane_sel, slip_count};
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got bs=%b act=%b lv=%b data=%h sel=%0d sc=%0d, required bs=%b act=%b lv=%b data=%h sel=%0d sc=%0d",
                  nm, got.bs, got.act, got.lv, got.data, got.sel, got.sc,
                  exp.bs, exp.act, exp.lv, exp.data, exp.sel, exp.sc);
      end
   endtask

   initial begin
      // Reset state
      add(1, 0, 8'h00, 0, 0);
      add(1, 0, 8'h00, 0, 0);
      // Four commas, one valid every fourth cycle
      for (int k = 1; k <= 4; k++) begin
         for (int j = 0; j < 3; j++) add(0, 0, 8'h00, 0, 0);
         if (k == 4) e_act = 1'b1;
         add(0, 1, BC, 0, 0);
      end
      add(0, 0, 8'h00, 0, 0);
      // Eight misses -> one slip, then lock
      e_act = 1'b0;
      add(1, 0, 8'h00, 0, 0);
      for (int i = 1; i <= 8; i++) begin
         if (i == 8) e_sc = 4'd1;
         add(0, 1, 8'h5E, (i == 8), 0);
      end
      add(0, 0, 8'h00, 0, 0);
      for (int k = 1; k <= 4; k++) begin
         if (k == 4) e_act = 1'b1;
         add(0, 1, BC, 0, 0);
      end
      // Round-robin distribution and comma stripping
      for (int i = 0; i < 5; i++) begin
         e_data = 8'(8'h11 * (i + 1));
         e_sel  = 2'(i % 4);
         add(0, 1, e_data, 0, 1);
      end
      add(0, 1, BC, 0, 0);
      e_data = 8'h66; e_sel = 2'd0;
      add(0, 1, 8'h66, 0, 1);
      // MAX_GAP data bytes without a comma drop the link
      add(0, 1, BC, 0, 0);
      for (int i = 0; i < 16; i++) begin
         e_data = 8'(8'h80 + i);
         e_sel  = 2'(i % 4);
         if (i == 15) e_act = 1'b0;
         add(0, 1, e_data, 0, 1);
      end
      add(0, 1, BC, 0, 0);
      add(0, 1, BC, 0, 0);
      add(0, 1, BC, 0, 0);
      add(0, 1, 8'h01, 0, 0);
      add(0, 0, 8'h00, 0, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].vld, vecs[i].b);
         check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Reset mid-run discards a partial comma run and wins over a valid byte
      e_act = 1'b0; e_data = 8'h00; e_sel = 2'd0; e_sc = 4'd0;
      drive(1, 0, 8'h00);
      check("rst_a", mk(0, 0));
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, BC);
         check($sformatf("pre_rst_comma%0d", k), mk(0, 0));
      end
      drive(1, 1, BC);
      check("rst_with_valid", mk(0, 0));
      for (int k = 1; k <= 4; k++) begin
         e_act = (k == 4);
         drive(0, 1, BC);
         check($sformatf("post_rst_comma%0d", k), mk(0, 0));
      end

      // Long idle while active keeps state and lane pointer
      e_data = 8'h11; e_sel = 2'd0;
      drive(0, 1, 8'h11);
      check("idle_pre0", mk(0, 1));
      e_data = 8'h22; e_sel = 2'd1;
      drive(0, 1, 8'h22);
      check("idle_pre1", mk(0, 1));
      for (int c = 0; c < 20; c++) begin
         drive(0, 0, 8'hEE);
         check($sformatf("idle%0d", c), mk(0, 0));
      end
      e_data = 8'h33; e_sel = 2'd2;
      drive(0, 1, 8'h33);
      check("idle_resume", mk(0, 1));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
